// File: rtl/vdp_tile_address_pipeline.sv
// Two-stage VDP tile row address generator with per-layer base/scroll configuration.
// Define VDP_TALL_TILE_EN to build in 16-pixel-high tile support.
module vdp_tile_address_pipeline #(
    parameter int unsigned LAYERS            = 4,
    parameter int unsigned ADDR_WIDTH        = 14,
    parameter int unsigned TILE_NUMBER_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  cfg_write,
    input  logic [2:0]            cfg_layer,
    input  logic [1:0]            cfg_select,
    input  logic [15:0]           cfg_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_layer,
    input  logic [3:0]            in_raster_y,
    input  logic [15:0]           in_map_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_address,
    output logic [2:0]            out_layer
);

    localparam int unsigned OFF_WIDTH = TILE_NUMBER_WIDTH + 3;
    localparam int unsigned SUM_WIDTH = (ADDR_WIDTH > OFF_WIDTH) ? ADDR_WIDTH : OFF_WIDTH;

    logic [ADDR_WIDTH-1:0] tile_base [LAYERS];
    logic [3:0]            scroll_y  [LAYERS];
`ifdef VDP_TALL_TILE_EN
    logic [LAYERS-1:0]     tall;
`endif

    // Selected layer configuration for the word being offered
    logic [ADDR_WIDTH-1:0] sel_base;
    logic [3:0]            sel_scroll;
    logic                  sel_tall;
    logic                  sel_ok;

    logic                         s1_valid;
    logic [TILE_NUMBER_WIDTH-1:0] s1_tile;
    logic                         s1_flip;
    logic [3:0]                   s1_raster_y;
    logic [ADDR_WIDTH-1:0]        s1_base;
    logic [3:0]                   s1_scroll;
    logic                         s1_tall;
    logic                         s1_layer_ok;
    logic [2:0]                   s1_layer;

    logic                  s2_adv;
    logic                  s1_load;
    logic [3:0]            row_sum;
    logic [3:0]            row4;
    logic [OFF_WIDTH-1:0]  offset;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  unused_bits;

    assign unused_bits = ^{cfg_data, in_map_data, s1_tall};

    assign s2_adv    = !out_valid || out_ready;
    assign s1_load   = !s1_valid || s2_adv;
    assign in_ready  = !reset && !flush && s1_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < LAYERS; l++) begin
                tile_base[l] <= '0;
                scroll_y[l]  <= '0;
            end
`ifdef VDP_TALL_TILE_EN
            tall <= '0;
`endif
        end else if (cfg_write) begin
            for (int l = 0; l < LAYERS; l++) begin
                if (cfg_layer == 3'(l)) begin
                    case (cfg_select)
                        2'd0: tile_base[l] <= ADDR_WIDTH'(cfg_data);
                        2'd1: scroll_y[l]  <= cfg_data[3:0];
`ifdef VDP_TALL_TILE_EN
                        2'd2: tall[l]      <= cfg_data[0];
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        sel_base   = '0;
        sel_scroll = '0;
        sel_tall   = 1'b0;
        sel_ok     = 1'b0;
        for (int l = 0; l < LAYERS; l++) begin
            if (in_layer == 3'(l)) begin
                sel_base   = tile_base[l];
                sel_scroll = scroll_y[l];
`ifdef VDP_TALL_TILE_EN
                sel_tall   = tall[l];
`endif
                sel_ok     = 1'b1;
            end
        end
    end

    // Row within the tile; row4[2:0] is also the flipped 8-pixel row
    always_comb begin
        row_sum = s1_scroll + s1_raster_y;
        row4    = row_sum ^ {4{s1_flip}};
        offset  = {s1_tile, row4[2:0]};
`ifdef VDP_TALL_TILE_EN
        if (s1_tall) begin
            offset = {s1_tile + (row4[3] ? TILE_NUMBER_WIDTH'(16) : '0), row4[2:0]};
        end
`endif
        addr_next = s1_layer_ok ? ADDR_WIDTH'(SUM_WIDTH'(s1_base) + SUM_WIDTH'(offset)) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_tile     <= '0;
            s1_flip     <= 1'b0;
            s1_raster_y <= '0;
            s1_base     <= '0;
            s1_scroll   <= '0;
            s1_tall     <= 1'b0;
            s1_layer_ok <= 1'b0;
            s1_layer    <= '0;
            out_valid   <= 1'b0;
            out_address <= '0;
            out_layer   <= '0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_address <= addr_next;
                    out_layer   <= s1_layer;
                end
            end
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_tile     <= in_map_data[TILE_NUMBER_WIDTH-1:0];
                    s1_flip     <= in_map_data[10];
                    s1_raster_y <= in_raster_y;
                    s1_base     <= sel_base;
                    s1_scroll   <= sel_scroll;
                    s1_tall     <= sel_tall;
                    s1_layer_ok <= sel_ok;
                    s1_layer    <= in_layer;
                end
            end
        end
    end

endmodule

// File: tb/tb_vdp_tile_address_pipeline.sv
// Randomized bench for vdp_tile_address_pipeline: a latency-tagged queue model plus
// hand-computed address checks; honours VDP_TALL_TILE_EN like the design.
module tb_vdp_tile_address_pipeline;

    localparam int unsigned LAYERS = 4;
    localparam int unsigned AW     = 14;
    localparam int unsigned TNW    = 9;

    logic          clk = 1'b0;
    logic          reset, flush, cfg_write, in_valid, out_ready;
    logic [2:0]    cfg_layer, in_layer;
    logic [1:0]    cfg_select;
    logic [15:0]   cfg_data, in_map_data;
    logic [3:0]    in_raster_y;
    logic          in_ready, out_valid;
    logic [AW-1:0] out_address;
    logic [2:0]    out_layer;

    vdp_tile_address_pipeline #(
        .LAYERS(LAYERS), .ADDR_WIDTH(AW), .TILE_NUMBER_WIDTH(TNW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .cfg_write(cfg_write), .cfg_layer(cfg_layer), .cfg_select(cfg_select),
        .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_layer(in_layer),
        .in_raster_y(in_raster_y), .in_map_data(in_map_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_address(out_address), .out_layer(out_layer)
    );

    always #5 clk = ~clk;

    // Inputs for the next step
    logic        n_reset, n_flush, n_cfg_write, n_in_valid, n_out_ready;
    logic [2:0]  n_cfg_layer, n_in_layer;
    logic [1:0]  n_cfg_select;
    logic [15:0] n_cfg_data, n_in_map_data;
    logic [3:0]  n_in_raster_y;

    typedef struct {
        int unsigned addr;
        int unsigned layer;
        int          due;
    } exp_t;

    exp_t        q[$];
    int unsigned m_base[8], m_scroll[8], m_tall[8];
    int unsigned obs[$];
    int          vectors = 0, miscompares = 0, cyc = 0;
    bit          last_acc, recording = 0;

    function automatic int unsigned model_addr(int unsigned base, int unsigned scroll,
                                               int unsigned ry, int unsigned map,
                                               int unsigned tall);
        int unsigned sum, flip, tile, r, off;
        sum  = (scroll + ry) % 16;
        flip = (map >> 10) & 1;
        tile = map % (1 << TNW);
        if (tall != 0) begin
            r    = (flip != 0) ? 15 - sum : sum;
            tile = (tile + ((r >= 8) ? 16 : 0)) % (1 << TNW);
            off  = tile * 8 + r % 8;
        end else begin
            r   = (flip != 0) ? 7 - (sum % 8) : sum % 8;
            off = tile * 8 + r;
        end
        return (base + off) % (1 << AW);
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic idle();
        n_reset = 0; n_flush = 0; n_cfg_write = 0; n_cfg_layer = 0; n_cfg_select = 0;
        n_cfg_data = 0; n_in_valid = 0; n_in_layer = 0; n_in_raster_y = 0;
        n_in_map_data = 0; n_out_ready = 1;
    endtask

    // One clock: apply inputs, compare against the model, then advance the model
    task automatic step();
        bit   exp_ov, exp_ir;
        exp_t e;
        @(negedge clk);
        reset = n_reset; flush = n_flush; cfg_write = n_cfg_write; cfg_layer = n_cfg_layer;
        cfg_select = n_cfg_select; cfg_data = n_cfg_data; in_valid = n_in_valid;
        in_layer = n_in_layer; in_raster_y = n_in_raster_y; in_map_data = n_in_map_data;
        out_ready = n_out_ready;
        #1;
        vectors++;
        if (reset) begin
            q.delete();
            for (int l = 0; l < 8; l++) begin
                m_base[l] = 0; m_scroll[l] = 0; m_tall[l] = 0;
            end
        end
        exp_ov = !reset && q.size() > 0 && q[0].due <= cyc;
        exp_ir = !reset && !flush && (q.size() < 2 || (exp_ov && out_ready));
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, exp_ir);
        if (reset) begin
            chk("reset_out_address", out_address, 0);
            chk("reset_out_layer", out_layer, 0);
        end else if (exp_ov) begin
            chk("out_address", out_address, q[0].addr);
            chk("out_layer", out_layer, q[0].layer);
        end
        if (recording && out_valid && out_ready) obs.push_back(out_layer);
        last_acc = 0;
        if (!reset) begin
            if (flush) begin
                q.delete();
            end else begin
                if (exp_ov && out_ready) void'(q.pop_front());
                if (in_valid && exp_ir) begin
                    last_acc = 1;
                    e.addr  = (in_layer < LAYERS) ?
                              model_addr(m_base[in_layer], m_scroll[in_layer], in_raster_y,
                                         in_map_data, m_tall[in_layer]) : 0;
                    e.layer = in_layer;
                    e.due   = cyc + 2;
                    q.push_back(e);
                end
            end
            if (cfg_write && cfg_layer < LAYERS) begin
                case (cfg_select)
                    2'd0: m_base[cfg_layer] = cfg_data % (1 << AW);
                    2'd1: m_scroll[cfg_layer] = cfg_data % 16;
`ifdef VDP_TALL_TILE_EN
                    2'd2: m_tall[cfg_layer] = cfg_data % 2;
`endif
                    default: ;
                endcase
            end
        end
        cyc++;
    endtask

    task automatic cfg(input int unsigned l, input int unsigned sel, input int unsigned d);
        idle();
        n_cfg_write = 1; n_cfg_layer = 3'(l); n_cfg_select = 2'(sel); n_cfg_data = 16'(d);
        step();
        n_cfg_write = 0;
    endtask

    task automatic send(input int unsigned l, input int unsigned ry, input int unsigned map);
        n_in_valid = 1; n_in_layer = 3'(l); n_in_raster_y = 4'(ry); n_in_map_data = 16'(map);
        step();
        n_in_valid = 0;
    endtask

    task automatic expect_out(input string name, input int unsigned addr);
        chk({name, "_valid"}, out_valid, 1);
        chk(name, out_address, addr);
    endtask

    initial begin
        int  idx;
        bit  saw_stall;
        idle();
        n_reset = 1;
        step(); step();
        n_reset = 0;
        step();
        chk("in_ready_after_reset", in_ready, 1);

        // Hand-computed values pin the model
        chk("model_basic", model_addr(32'h1000, 3, 2, 32'h0005, 0), 32'h102D);
        chk("model_flip", model_addr(32'h1000, 3, 2, 32'h0405, 0), 32'h102A);
        chk("model_wrap", model_addr(32'h3FFC, 0, 7, 32'h01FF, 0), 32'h0FFB);
        chk("model_tall", model_addr(0, 12, 1, 2, 1), 32'h095);
        chk("model_tall_flip", model_addr(0, 12, 1, 32'h402, 1), 32'h012);

        cfg(0, 0, 16'h1000);
        cfg(0, 1, 3);
        send(0, 2, 16'h0005); step(); step();
        expect_out("basic_addr", 16'h102D);
        send(0, 2, 16'h0405); step(); step();
        expect_out("flip_addr", 16'h102A);

        cfg(1, 0, 16'h3FFC);
        cfg(1, 1, 0);
        send(1, 7, 16'h01FF); step(); step();
        expect_out("wrap_addr", 16'h0FFB);

        // Config write in the same cycle as acceptance must not affect that word
        n_cfg_write = 1; n_cfg_layer = 0; n_cfg_select = 0; n_cfg_data = 16'h2000;
        send(0, 2, 16'h0005);
        n_cfg_write = 0;
        step(); step();
        expect_out("same_cycle_cfg_old", 16'h102D);
        send(0, 2, 16'h0005); step(); step();
        expect_out("same_cycle_cfg_new", 16'h202D);

        send(5, 2, 16'h0005); step(); step();
        chk("bad_layer_valid", out_valid, 1);
        chk("bad_layer_addr", out_address, 0);
        chk("bad_layer_layer", out_layer, 5);

`ifdef VDP_TALL_TILE_EN
        cfg(2, 0, 0);
        cfg(2, 1, 12);
        cfg(2, 2, 1);
        send(2, 1, 16'h0002); step(); step();
        expect_out("tall_addr", 16'h095);
        send(2, 1, 16'h0402); step(); step();
        expect_out("tall_flip_addr", 16'h012);
        cfg(2, 2, 0);
`else
        cfg(2, 0, 0);
        cfg(2, 1, 12);
        cfg(2, 2, 1);
        send(2, 1, 16'h0002); step(); step();
        expect_out("tall_ignored_addr", 16'h015);
`endif

        // Four-word stream with a 3-cycle output stall
        cfg(3, 0, 16'h0800);
        idle();
        idx = 0; saw_stall = 0; obs.delete(); recording = 1;
        for (int k = 0; k < 16; k++) begin
            n_in_valid = (idx < 4); n_in_layer = 3'(idx);
            n_in_raster_y = 4'(k); n_in_map_data = 16'(k * 37);
            n_out_ready = !(k >= 2 && k < 5);
            step();
            if (n_in_valid && !in_ready) saw_stall = 1;
            if (last_acc) idx++;
        end
        recording = 0;
        chk("stream_stalled", saw_stall, 1);
        chk("stream_accepted", idx, 4);
        chk("stream_count", obs.size(), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++) chk("stream_order", obs[i], i);

        // Flush with two words in flight under backpressure
        idle();
        n_out_ready = 0;
        send(0, 1, 16'h0011);
        send(1, 4, 16'h0022);
        step();
        chk("pre_flush_valid", out_valid, 1);
        n_flush = 1; n_in_valid = 1;
        step();
        n_flush = 0; n_in_valid = 0; n_out_ready = 1;
        send(0, 2, 16'h0005);
        chk("post_flush_valid", out_valid, 0);
        step(); step();
        expect_out("post_flush_addr", 16'h202D);

        // Mid-transaction reset
        send(0, 2, 16'h0005);
        n_reset = 1; step(); n_reset = 0;
        step();
        chk("reset_drop_valid", out_valid, 0);
        chk("reset_ready", in_ready, 1);

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            n_reset       = ($urandom_range(0, 299) == 0);
            n_flush       = ($urandom_range(0, 29) == 0);
            n_cfg_write   = ($urandom_range(0, 3) == 0);
            n_cfg_layer   = 3'($urandom_range(0, 7));
            n_cfg_select  = 2'($urandom_range(0, 3));
            n_cfg_data    = 16'($urandom);
            n_in_valid    = ($urandom_range(0, 9) < 7);
            n_in_layer    = 3'($urandom_range(0, 5));
            n_in_raster_y = 4'($urandom);
            n_in_map_data = 16'($urandom);
            n_out_ready   = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
